// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-cache, D-cache and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between I-cache and D-cache.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            state, state_n;
    logic              last_d;
    logic              d_req, pick_d;
    logic              d_read_l, d_write_l;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    assign d_req  = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time gets the port.
    assign pick_d = d_req & (~bus.i_read | ~last_d);

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    always_comb begin
        state_n       = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;
        if (state == IDLE)
            state_n = (bus.i_read | d_req) ? (pick_d ? GRANT_D : GRANT_I) : IDLE;
        else if (bus.mem_resp)
            state_n = IDLE;
        bus.mem_read  = (state == GRANT_I) || (state == GRANT_D && d_read_l);
        bus.mem_write = (state == GRANT_D) && d_write_l;
        bus.i_resp    = (state == GRANT_I) && bus.mem_resp;
        bus.d_resp    = (state == GRANT_D) && bus.mem_resp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            d_read_l  <= 1'b0;
            d_write_l <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) begin
                last_d    <= pick_d;
                addr_q    <= pick_d ? bus.d_addr : bus.i_addr;
                // Simultaneous d_read and d_write is resolved as a write.
                d_write_l <= pick_d & bus.d_write;
                d_read_l  <= pick_d & bus.d_read & ~bus.d_write;
                if (pick_d & bus.d_write)
                    wdata_q <= bus.d_wdata;
            end
        end
    end
endmodule
